ex_mem_latch: RTL and testbench
===============================

Name: ex_mem_latch

Overview:
- Pipeline register between the EX stage (ALU output) and the MEM stage of the 5-stage MIPS core.
- Captures the ALU result, the ALU zero flag, store data, destination register and MEM/WB control bits.
- Resolves the branch decision, registered as pc_src, for the fetch stage.
- Supports stall (hold), flush (bubble) and a halt-drain state machine.

Parameters:
NBITS, 32, datapath width (ALU result, store data, PC values)
NREG, 5, register-address width

Ports:
clk  input  1  core clock; all state updates on rising edge
rst_n  input  1  asynchronous active-low reset
stall  input  1  hold all registered outputs (MEM stage busy / hazard)
flush  input  1  insert bubble: clears valid and all control outputs
ex_valid  input  1  EX stage holds a real instruction
ex_result  input  NBITS  ALU result_op
ex_zero  input  1  ALU zero flag
ex_store_data  input  NBITS  forwarded rt value for stores
ex_rd  input  NREG  destination register
ex_branch_target  input  NBITS  computed branch target
ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg, ex_branch, ex_halt  input  1 each  control bits
ex_mem_width  input  2  00 byte, 01 half, 11 word
mem_valid  output  1  registered valid
mem_result  output  NBITS  registered ALU result (memory address or WB value)
mem_store_data  output  NBITS  registered store data
mem_rd  output  NREG  registered destination
mem_reg_write, mem_mem_read, mem_mem_write, mem_mem_to_reg  output  1 each  registered control
mem_mem_width  output  2  registered width
pc_src  output  1  take branch (registered)
pc_branch_target  output  NBITS  registered target
halted  output  1  pipeline drained after halt

Behaviour:
- Reset (rst_n low, asynchronous): every output 0; FSM = RUN.
- Latency: 1 cycle EX -> MEM for all fields.
- Priority per edge: flush > stall > load.
- flush:
  - mem_valid, all control outputs and pc_src go to 0.
  - Data fields (result, store data, rd, target) load normally; they are don't-care in a bubble.
- stall without flush: all outputs hold their value; pc_src also holds.
- Load:
  - Control outputs = ex_* AND ex_valid; an invalid EX slot never writes a register or memory.
  - pc_src = ex_valid & ex_branch & ex_zero.
  - ex_zero is valid only when ALU_control selects SUB (0111); the decoder must issue SUB for branches.
- ex_mem_read and ex_mem_write both set: treat as mem_write only. mem_mem_read = 0.
- Halt FSM:
  - RUN: a load with ex_valid & ex_halt goes to DRAIN.
  - DRAIN: stays 2 unstalled cycles (MEM and WB retire), counted by a 2-bit counter; stall freezes the counter. Then goes to HALTED.
  - HALTED: halted = 1; all further loads are forced to bubbles (valid/control 0) until reset.
  - flush in DRAIN does not cancel the halt, since the halt has already reached MEM.
  - A halt that is flushed while still in EX never enters DRAIN.
- Reset asserted mid-DRAIN: returns to RUN immediately.

Optional Feature:
- Macro EX_MEM_BNE_EN.
- Enabled:
  - Adds input ex_branch_ne (1 bit).
  - pc_src = ex_valid & ((ex_branch & ex_zero) | (ex_branch_ne & ~ex_zero)).
  - ex_branch and ex_branch_ne both set: pc_src = ex_valid.
- Disabled:
  - Port absent; only beq semantics apply.

Decomposition:
- Shared package (core_pkg) holds:
  - NBITS/NREG defaults.
  - mem_width encodings: MW_BYTE = 2'b00, MW_HALF = 2'b01, MW_WORD = 2'b11.
  - ALU opcode constant ALU_SUB = 4'b0111.
  - Halt FSM state encodings: RUN, DRAIN, HALTED.
- One natural sub-module, pipe_reg: a parameterised-width register with enable and synchronous clear, instantiated for the data and control groups.
- The FSM and pc_src logic stay in ex_mem_latch.

Test Plan:
1. Reset then load:
   - Stimulus: ex_valid = 1, ex_result = 0x00000010, ex_reg_write = 1, ex_rd = 5.
   - Response: next cycle mem_result = 0x10, mem_rd = 5, mem_reg_write = 1, mem_valid = 1.
2. Branch:
   - Stimulus: ex_branch = 1, ex_zero = 1, target 0x40.
   - Response: pc_src = 1, pc_branch_target = 0x40.
   - With ex_zero = 0: pc_src = 0.
   - With ex_valid = 0: pc_src = 0.
3. Stall/flush:
   - Load 0xDEADBEEF, then stall 3 cycles while inputs change: outputs hold 0xDEADBEEF.
   - Assert stall + flush together: mem_valid = 0, mem_mem_write = 0.
4. Conflicting memory controls:
   - Stimulus: ex_mem_read = 1 and ex_mem_write = 1.
   - Response: mem_mem_write = 1, mem_mem_read = 0.
5. Halt:
   - Stimulus: load with ex_halt = 1, one stall cycle inserted during DRAIN.
   - Response: halted rises exactly 3 cycles after the halt is latched.
   - Subsequent valid inputs produce mem_valid = 0.
   - rst_n pulse clears halted.
6. EX_MEM_BNE_EN build:
   - Stimulus: ex_branch_ne = 1, ex_zero = 0.
   - Response: pc_src = 1.
   - With ex_zero = 1: pc_src = 0.

Source files
------------

// File: rtl/core_pkg.sv
// Shared definitions for the core pipeline: default widths, memory-width
// encodings, ALU opcodes and the halt-drain state encoding.
package core_pkg;

    localparam int NBITS_DEF = 32;
    localparam int NREG_DEF  = 5;

    localparam logic [1:0] MW_BYTE = 2'b00;
    localparam logic [1:0] MW_HALF = 2'b01;
    localparam logic [1:0] MW_WORD = 2'b11;

    // Branch compare relies on the zero flag, which is only meaningful for SUB.
    localparam logic [3:0] ALU_SUB = 4'b0111;

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        DRAIN  = 2'd1,
        HALTED = 2'd2
    } halt_state_t;

endpackage

// File: rtl/pipe_reg.sv
// Parameterised pipeline register group with load enable and synchronous
// clear (clear wins over enable).
module pipe_reg #(
    parameter int W = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         en,
    input  logic         clr,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= '0;
        end else if (clr) begin
            q <= '0;
        end else if (en) begin
            q <= d;
        end
    end

endmodule

// File: rtl/ex_mem_latch.sv
// EX/MEM pipeline register with branch resolution and halt-drain FSM.
// Optional macro EX_MEM_BNE_EN adds ex_branch_ne (bne) support.
//
// state  | meaning
// RUN    | normal operation, watching for a halt being loaded
// DRAIN  | halt is in MEM; waiting two unstalled cycles for MEM/WB to retire
// HALTED | pipeline drained; every further load becomes a bubble
module ex_mem_latch
    import core_pkg::*;
#(
    parameter int NBITS = NBITS_DEF,
    parameter int NREG  = NREG_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             stall,
    input  logic             flush,
    input  logic             ex_valid,
    input  logic [NBITS-1:0] ex_result,
    input  logic             ex_zero,
    input  logic [NBITS-1:0] ex_store_data,
    input  logic [NREG-1:0]  ex_rd,
    input  logic [NBITS-1:0] ex_branch_target,
    input  logic             ex_reg_write,
    input  logic             ex_mem_read,
    input  logic             ex_mem_write,
    input  logic             ex_mem_to_reg,
    input  logic             ex_branch,
`ifdef EX_MEM_BNE_EN
    input  logic             ex_branch_ne,
`endif
    input  logic             ex_halt,
    input  logic [1:0]       ex_mem_width,
    output logic             mem_valid,
    output logic [NBITS-1:0] mem_result,
    output logic [NBITS-1:0] mem_store_data,
    output logic [NREG-1:0]  mem_rd,
    output logic             mem_reg_write,
    output logic             mem_mem_read,
    output logic             mem_mem_write,
    output logic             mem_mem_to_reg,
    output logic [1:0]       mem_mem_width,
    output logic             pc_src,
    output logic [NBITS-1:0] pc_branch_target,
    output logic             halted
);

    localparam int CW = 8;
    localparam int DW = 3 * NBITS + NREG;

    halt_state_t state, state_n;
    logic [1:0]  drain_cnt, drain_cnt_n;
    logic        v_eff;
    logic        take;
    logic        load;
    logic [CW-1:0] ctrl_d, ctrl_q;
    logic [DW-1:0] data_d, data_q;

    assign load  = ~flush & ~stall;
    assign v_eff = ex_valid & (state != HALTED);

`ifdef EX_MEM_BNE_EN
    assign take = (ex_branch & ex_zero) | (ex_branch_ne & ~ex_zero);
`else
    assign take = ex_branch & ex_zero;
`endif

    // A read+write conflict resolves to a store only.
    assign ctrl_d = {v_eff,
                     ex_reg_write & v_eff,
                     ex_mem_read & ~ex_mem_write & v_eff,
                     ex_mem_write & v_eff,
                     ex_mem_to_reg & v_eff,
                     ex_mem_width & {2{v_eff}},
                     take & v_eff};

    assign data_d = {ex_result, ex_store_data, ex_rd, ex_branch_target};

    pipe_reg #(.W(CW)) u_ctrl (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (~stall),
        .clr   (flush),
        .d     (ctrl_d),
        .q     (ctrl_q)
    );

    // Data fields are don't-care in a bubble, so a flush still loads them.
    pipe_reg #(.W(DW)) u_data (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (~stall | flush),
        .clr   (1'b0),
        .d     (data_d),
        .q     (data_q)
    );

    assign {mem_valid, mem_reg_write, mem_mem_read, mem_mem_write,
            mem_mem_to_reg, mem_mem_width, pc_src} = ctrl_q;
    assign {mem_result, mem_store_data, mem_rd, pc_branch_target} = data_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= RUN;
            drain_cnt <= 2'd0;
        end else begin
            state     <= state_n;
            drain_cnt <= drain_cnt_n;
        end
    end

    always_comb begin
        state_n     = state;
        drain_cnt_n = drain_cnt;
        case (state)
            RUN: begin
                if (load && ex_valid && ex_halt) begin
                    state_n     = DRAIN;
                    drain_cnt_n = 2'd0;
                end
            end
            DRAIN: begin
                if (!stall) begin
                    if (drain_cnt == 2'd1) begin
                        state_n     = HALTED;
                        drain_cnt_n = 2'd0;
                    end else begin
                        drain_cnt_n = drain_cnt + 2'd1;
                    end
                end
            end
            HALTED: begin
                state_n = HALTED;
            end
            default: begin
                state_n     = RUN;
                drain_cnt_n = 2'd0;
            end
        endcase
    end

    assign halted = (state == HALTED);

endmodule

// File: tb/tb_ex_mem_latch.sv
// Self-checking bench for ex_mem_latch: vector table driven through a
// scoreboard, plus hand-written halt/reset sequences.
module tb_ex_mem_latch;

    logic        clk;
    logic        rst_n;
    logic        stall, flush, ex_valid, ex_zero;
    logic [31:0] ex_result, ex_store_data, ex_branch_target;
    logic [4:0]  ex_rd;
    logic        ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg;
    logic        ex_branch, ex_halt;
    logic [1:0]  ex_mem_width;
`ifdef EX_MEM_BNE_EN
    logic        ex_branch_ne;
`endif
    logic        mem_valid;
    logic [31:0] mem_result, mem_store_data, pc_branch_target;
    logic [4:0]  mem_rd;
    logic        mem_reg_write, mem_mem_read, mem_mem_write, mem_mem_to_reg;
    logic [1:0]  mem_mem_width;
    logic        pc_src, halted;

    int checks   = 0;
    int failures = 0;

    typedef struct packed {
        logic        valid;
        logic [31:0] result;
        logic [31:0] sdata;
        logic [4:0]  rd;
        logic        rw, mr, mw, m2r;
        logic [1:0]  w;
        logic        pc;
        logic [31:0] tgt;
        logic        hlt;
    } obs_t;

    typedef struct {
        string       name;
        logic        st, fl, v;
        logic [31:0] res;
        logic        z;
        logic [31:0] sd;
        logic [4:0]  rd;
        logic [31:0] tg;
        logic        rw, mr, mw, m2r, br, bne, h;
        logic [1:0]  w;
        obs_t        exp;
    } vec_t;

    vec_t vecs[$];
    obs_t sb[$];

    ex_mem_latch dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .stall            (stall),
        .flush            (flush),
        .ex_valid         (ex_valid),
        .ex_result        (ex_result),
        .ex_zero          (ex_zero),
        .ex_store_data    (ex_store_data),
        .ex_rd            (ex_rd),
        .ex_branch_target (ex_branch_target),
        .ex_reg_write     (ex_reg_write),
        .ex_mem_read      (ex_mem_read),
        .ex_mem_write     (ex_mem_write),
        .ex_mem_to_reg    (ex_mem_to_reg),
        .ex_branch        (ex_branch),
`ifdef EX_MEM_BNE_EN
        .ex_branch_ne     (ex_branch_ne),
`endif
        .ex_halt          (ex_halt),
        .ex_mem_width     (ex_mem_width),
        .mem_valid        (mem_valid),
        .mem_result       (mem_result),
        .mem_store_data   (mem_store_data),
        .mem_rd           (mem_rd),
        .mem_reg_write    (mem_reg_write),
        .mem_mem_read     (mem_mem_read),
        .mem_mem_write    (mem_mem_write),
        .mem_mem_to_reg   (mem_mem_to_reg),
        .mem_mem_width    (mem_mem_width),
        .pc_src           (pc_src),
        .pc_branch_target (pc_branch_target),
        .halted           (halted)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic obs_t sample();
        return {mem_valid, mem_result, mem_store_data, mem_rd, mem_reg_write,
                mem_mem_read, mem_mem_write, mem_mem_to_reg, mem_mem_width,
                pc_src, pc_branch_target, halted};
    endfunction

    function automatic obs_t mk(logic v, logic [31:0] res, logic [31:0] sd,
                                logic [4:0] rd, logic rw, logic mr, logic mw,
                                logic m2r, logic [1:0] w, logic pc,
                                logic [31:0] tg);
        obs_t o;
        o = {v, res, sd, rd, rw, mr, mw, m2r, w, pc, tg, 1'b0};
        return o;
    endfunction

    task automatic add(string n, logic st, logic fl, logic v, logic [31:0] res,
                       logic z, logic [31:0] sd, logic [4:0] rd, logic [31:0] tg,
                       logic rw, logic mr, logic mw, logic m2r, logic br,
                       logic bne, logic h, logic [1:0] w, obs_t e);
        vec_t x;
        x.name = n; x.st = st; x.fl = fl; x.v = v; x.res = res; x.z = z;
        x.sd = sd; x.rd = rd; x.tg = tg; x.rw = rw; x.mr = mr; x.mw = mw;
        x.m2r = m2r; x.br = br; x.bne = bne; x.h = h; x.w = w; x.exp = e;
        vecs.push_back(x);
    endtask

    task automatic check(string n, logic [127:0] act, logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s got=%h expected=%h", n, act, exp);
        end
    endtask

    task automatic idle();
        stall = 0; flush = 0; ex_valid = 0; ex_zero = 0;
        ex_result = '0; ex_store_data = '0; ex_branch_target = '0; ex_rd = '0;
        ex_reg_write = 0; ex_mem_read = 0; ex_mem_write = 0; ex_mem_to_reg = 0;
        ex_branch = 0; ex_halt = 0; ex_mem_width = 2'b00;
`ifdef EX_MEM_BNE_EN
        ex_branch_ne = 0;
`endif
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        rst_n = 0;
        #1;
        check("reset_async_halted", {127'd0, halted}, 128'd0);
        check("reset_async_valid",  {127'd0, mem_valid}, 128'd0);
        #1;
        rst_n = 1;
    endtask

    initial begin
        idle();
        rst_n = 0;
        #12;
        check("reset_state", {18'd0, sample()}, 128'd0);
        @(negedge clk);
        rst_n = 1;

        //  name            st fl v  result        z  sdata         rd tgt           rw mr mw m2r br bne h  w
        add("load_basic",   0, 0, 1, 32'h10,       0, 32'h0,        5, 32'h0,        1, 0, 0, 0, 0, 0, 0, 2'b11,
            mk(1, 32'h10, 32'h0, 5, 1, 0, 0, 0, 2'b11, 0, 32'h0));
        add("beq_taken",    0, 0, 1, 32'h0,        1, 32'h0,        0, 32'h40,       0, 0, 0, 0, 1, 0, 0, 2'b00,
            mk(1, 32'h0, 32'h0, 0, 0, 0, 0, 0, 2'b00, 1, 32'h40));
        add("beq_nz",       0, 0, 1, 32'h0,        0, 32'h0,        0, 32'h40,       0, 0, 0, 0, 1, 0, 0, 2'b00,
            mk(1, 32'h0, 32'h0, 0, 0, 0, 0, 0, 2'b00, 0, 32'h40));
        add("beq_invalid",  0, 0, 0, 32'h0,        1, 32'h0,        0, 32'h40,       0, 0, 0, 0, 1, 0, 0, 2'b00,
            mk(0, 32'h0, 32'h0, 0, 0, 0, 0, 0, 2'b00, 0, 32'h40));
        add("store_dead",   0, 0, 1, 32'hDEADBEEF, 0, 32'h12345678, 3, 32'h80,       0, 0, 1, 0, 0, 0, 0, 2'b11,
            mk(1, 32'hDEADBEEF, 32'h12345678, 3, 0, 0, 1, 0, 2'b11, 0, 32'h80));
        for (int i = 0; i < 3; i++)
            add("stall_hold", 1, 0, 1, 32'h11110000 + i, 1, 32'hFFFF, 9, 32'h100 + i, 1, 1, 0, 1, 1, 0, 0, 2'b01,
                mk(1, 32'hDEADBEEF, 32'h12345678, 3, 0, 0, 1, 0, 2'b11, 0, 32'h80));
        add("stall_flush",  1, 1, 1, 32'hCAFE0000, 1, 32'h55,       7, 32'hC0,       1, 0, 1, 0, 1, 0, 0, 2'b11,
            mk(0, 32'hCAFE0000, 32'h55, 7, 0, 0, 0, 0, 2'b00, 0, 32'hC0));
        add("rd_wr_confl",  0, 0, 1, 32'h100,      0, 32'hAA,       0, 32'h0,        0, 1, 1, 0, 0, 0, 0, 2'b11,
            mk(1, 32'h100, 32'hAA, 0, 0, 0, 1, 0, 2'b11, 0, 32'h0));
        add("load_half",    0, 0, 1, 32'h200,      0, 32'h0,        8, 32'h0,        1, 1, 0, 1, 0, 0, 0, 2'b01,
            mk(1, 32'h200, 32'h0, 8, 1, 1, 0, 1, 2'b01, 0, 32'h0));
        add("flush_branch", 0, 1, 1, 32'h300,      1, 32'h0,        2, 32'h44,       1, 0, 0, 0, 1, 0, 0, 2'b11,
            mk(0, 32'h300, 32'h0, 2, 0, 0, 0, 0, 2'b00, 0, 32'h44));
        add("invalid_ctrl", 0, 0, 0, 32'h400,      0, 32'h9,        4, 32'h0,        1, 1, 1, 1, 0, 0, 0, 2'b11,
            mk(0, 32'h400, 32'h9, 4, 0, 0, 0, 0, 2'b00, 0, 32'h0));
`ifdef EX_MEM_BNE_EN
        add("bne_taken",    0, 0, 1, 32'h0,        0, 32'h0,        0, 32'h60,       0, 0, 0, 0, 0, 1, 0, 2'b00,
            mk(1, 32'h0, 32'h0, 0, 0, 0, 0, 0, 2'b00, 1, 32'h60));
        add("bne_zero",     0, 0, 1, 32'h0,        1, 32'h0,        0, 32'h60,       0, 0, 0, 0, 0, 1, 0, 2'b00,
            mk(1, 32'h0, 32'h0, 0, 0, 0, 0, 0, 2'b00, 0, 32'h60));
        add("beq_bne_both", 0, 0, 1, 32'h0,        0, 32'h0,        0, 32'h64,       0, 0, 0, 0, 1, 1, 0, 2'b00,
            mk(1, 32'h0, 32'h0, 0, 0, 0, 0, 0, 2'b00, 1, 32'h64));
        add("bne_invalid",  0, 0, 0, 32'h0,        0, 32'h0,        0, 32'h68,       0, 0, 0, 0, 0, 1, 0, 2'b00,
            mk(0, 32'h0, 32'h0, 0, 0, 0, 0, 0, 2'b00, 0, 32'h68));
`endif

        foreach (vecs[k]) begin
            @(negedge clk);
            stall = vecs[k].st; flush = vecs[k].fl; ex_valid = vecs[k].v;
            ex_result = vecs[k].res; ex_zero = vecs[k].z; ex_store_data = vecs[k].sd;
            ex_rd = vecs[k].rd; ex_branch_target = vecs[k].tg;
            ex_reg_write = vecs[k].rw; ex_mem_read = vecs[k].mr;
            ex_mem_write = vecs[k].mw; ex_mem_to_reg = vecs[k].m2r;
            ex_branch = vecs[k].br; ex_halt = vecs[k].h; ex_mem_width = vecs[k].w;
`ifdef EX_MEM_BNE_EN
            ex_branch_ne = vecs[k].bne;
`endif
            sb.push_back(vecs[k].exp);
            tick();
            if (sb.size() == 0) begin
                failures++;
                $display("FAIL scoreboard_empty at %s", vecs[k].name);
            end else begin
                obs_t e;
                e = sb.pop_front();
                check(vecs[k].name, {18'd0, sample()}, {18'd0, e});
            end
        end

        // Halt with one stall in DRAIN: halted rises 3 cycles after latching.
        @(negedge clk); idle(); ex_valid = 1; ex_halt = 1;
        tick();
        check("halt_latched_valid", {127'd0, mem_valid}, 128'd1);
        check("halt_c0", {127'd0, halted}, 128'd0);
        @(negedge clk); idle();
        tick();
        check("halt_c1", {127'd0, halted}, 128'd0);
        @(negedge clk); stall = 1;
        tick();
        check("halt_c2_stalled", {127'd0, halted}, 128'd0);
        @(negedge clk); stall = 0;
        tick();
        check("halt_c3", {127'd0, halted}, 128'd1);
        @(negedge clk); idle(); ex_valid = 1; ex_reg_write = 1; ex_mem_write = 1; ex_result = 32'h77;
        tick();
        check("halted_bubble", {126'd0, mem_valid, mem_reg_write}, 128'd0);
        check("halted_bubble_mw", {127'd0, mem_mem_write}, 128'd0);
        check("halted_data_loads", {96'd0, mem_result}, {96'd0, 32'h77});
        pulse_reset();
        @(negedge clk); idle();
        tick();
        check("reset_cleared_halted", {127'd0, halted}, 128'd0);

        // Flush while in DRAIN does not cancel the halt.
        @(negedge clk); idle(); ex_valid = 1; ex_halt = 1;
        tick();
        @(negedge clk); idle(); flush = 1;
        tick();
        check("drain_flush_c1", {127'd0, halted}, 128'd0);
        @(negedge clk); idle();
        tick();
        check("drain_flush_c2", {127'd0, halted}, 128'd1);
        pulse_reset();

        // Halt flushed in EX never drains.
        @(negedge clk); idle(); ex_valid = 1; ex_halt = 1; flush = 1;
        tick();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); idle();
            tick();
        end
        check("flushed_halt_ignored", {127'd0, halted}, 128'd0);
        @(negedge clk); idle(); ex_valid = 1; ex_reg_write = 1; ex_rd = 5'd12;
        tick();
        check("run_after_flushed_halt", {121'd0, mem_valid, mem_reg_write, mem_rd}, {121'd0, 1'b1, 1'b1, 5'd12});

        // Reset during DRAIN returns to RUN.
        @(negedge clk); idle(); ex_valid = 1; ex_halt = 1;
        tick();
        @(negedge clk); idle();
        tick();
        pulse_reset();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); idle();
            tick();
        end
        check("reset_mid_drain", {127'd0, halted}, 128'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog_timeout");
        $fatal(1, "timeout");
    end

endmodule
